// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word fetches, queues {pc, instr} for decode.
// Define FETCH_STATS_EN to build the fetch/flush statistics counters.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter logic [31:0] IMEM_LIMIT = 32'h0040_0400,
   parameter int          DEPTH      = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   function automatic logic addr_ok(input logic [31:0] a);
      return (a >= RESET_PC) && (a < IMEM_LIMIT);
   endfunction

   logic [31:0]      r_pc;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_fault;
   logic [31:0]      r_fault_pc;
   logic [31:0]      r_q_pc    [DEPTH];
   logic [31:0]      r_q_instr [DEPTH];

   logic w_valid;
   logic w_pop;
   logic w_issue;
   logic w_redir_bad;

   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid & if_ready & ~redirect_valid;
   assign w_issue     = ~r_fault & ~redirect_valid & ((r_count < FULL) | w_pop) & addr_ok(r_pc);
   assign w_redir_bad = (redirect_pc[1:0] != 2'b00) | ~addr_ok(redirect_pc);

   // Control state: pc, queue pointers/occupancy, sticky fault
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_pc;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_fault    <= w_redir_bad;
         r_fault_pc <= w_redir_bad ? redirect_pc : 32'h0;
      end else begin
         if (w_issue) begin
            r_pc     <= r_pc + 32'd4;
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_issue && !w_pop)
            r_count <= r_count + CNT_ONE;
         else if (!w_issue && w_pop)
            r_count <= r_count - CNT_ONE;
         if (!r_fault && !addr_ok(r_pc)) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
         end
      end
   end

   // Queue payload carries no reset; head outputs are gated by occupancy instead
   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_q_pc[r_wr_ptr]    <= r_pc;
         r_q_instr[r_wr_ptr] <= imem_instr;
      end
   end

   assign imem_addr   = {r_pc[31:2], 2'b00};
   assign imem_req    = w_issue;
   assign if_valid    = w_valid;
   assign if_pc       = w_valid ? r_q_pc[r_rd_ptr]    : 32'h0;
   assign if_instr    = w_valid ? r_q_instr[r_rd_ptr] : 32'h0;
   assign fetch_fault = r_fault;
   assign fault_pc    = r_fault_pc;

`ifdef FETCH_STATS_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_issue)
            r_fetch_count <= r_fetch_count + 32'd1;
         if (redirect_valid)
            r_flush_count <= r_flush_count + {{(31-PTR_W){1'b0}}, r_count};
      end
   end

   assign fetch_count = r_fetch_count;
   assign flush_count = r_flush_count;
`else
   assign fetch_count = 32'h0;
   assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (default parameters, DEPTH=2).
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        fetch_fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;
   logic [31:0] flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   instruction_fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_instr(imem_instr),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_fault(fetch_fault), .fault_pc(fault_pc),
      .fetch_count(fetch_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // Memory word at each address is its word index from the start of memory
   assign imem_instr = (imem_addr - 32'h0040_0000) >> 2;

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          e_v;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      bit          e_req;
      bit          e_flt;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(bit rst, bit rdy, bit rv, logic [31:0] rpc,
                               bit e_v, logic [31:0] e_pc, logic [31:0] e_ins,
                               bit e_req, bit e_flt);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins; v.e_req = e_req; v.e_flt = e_flt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
      @(negedge clk);
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   initial begin
      bit found;

      // Segment 1: stream, back-pressure, full-queue redirect
      tbl[0]  = mk(1, 1, 0, 0,            0, 32'h0,        32'h0,  1, 0);
      tbl[1]  = mk(0, 1, 0, 0,            1, 32'h00400000, 32'h0,  1, 0);
      tbl[2]  = mk(0, 1, 0, 0,            1, 32'h00400004, 32'h1,  1, 0);
      tbl[3]  = mk(0, 0, 0, 0,            1, 32'h00400008, 32'h2,  1, 0);
      tbl[4]  = mk(0, 0, 0, 0,            1, 32'h00400008, 32'h2,  0, 0);
      tbl[5]  = mk(0, 0, 0, 0,            1, 32'h00400008, 32'h2,  0, 0);
      tbl[6]  = mk(0, 1, 0, 0,            1, 32'h00400008, 32'h2,  1, 0);
      tbl[7]  = mk(0, 1, 0, 0,            1, 32'h0040000C, 32'h3,  1, 0);
      tbl[8]  = mk(0, 0, 0, 0,            1, 32'h00400010, 32'h4,  0, 0);
      tbl[9]  = mk(0, 0, 1, 32'h00400100, 1, 32'h00400010, 32'h4,  0, 0);
      tbl[10] = mk(0, 0, 0, 0,            0, 32'h0,        32'h0,  1, 0);
      tbl[11] = mk(0, 1, 0, 0,            1, 32'h00400100, 32'h40, 1, 0);
      // Segment 2: ready held low for 5 cycles from reset, then released
      tbl[12] = mk(1, 0, 0, 0,            0, 32'h0,        32'h0,  1, 0);
      tbl[13] = mk(0, 0, 0, 0,            1, 32'h00400000, 32'h0,  1, 0);
      tbl[14] = mk(0, 0, 0, 0,            1, 32'h00400000, 32'h0,  0, 0);
      tbl[15] = mk(0, 0, 0, 0,            1, 32'h00400000, 32'h0,  0, 0);
      tbl[16] = mk(0, 0, 0, 0,            1, 32'h00400000, 32'h0,  0, 0);
      tbl[17] = mk(0, 1, 0, 0,            1, 32'h00400000, 32'h0,  1, 0);
      tbl[18] = mk(0, 1, 0, 0,            1, 32'h00400004, 32'h1,  1, 0);
      tbl[19] = mk(0, 1, 0, 0,            1, 32'h00400008, 32'h2,  1, 0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tbl[i].rst) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
         end
         if_ready       = tbl[i].rdy;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         #1;
         chk($sformatf("v%0d.if_valid", i),  32'(if_valid),    32'(tbl[i].e_v));
         chk($sformatf("v%0d.if_pc", i),     if_pc,            tbl[i].e_pc);
         chk($sformatf("v%0d.if_instr", i),  if_instr,         tbl[i].e_ins);
         chk($sformatf("v%0d.imem_req", i),  32'(imem_req),    32'(tbl[i].e_req));
         chk($sformatf("v%0d.fault", i),     32'(fetch_fault), 32'(tbl[i].e_flt));
         chk($sformatf("v%0d.addr_lsb", i),  32'(imem_addr[1:0]), 32'h0);
         if (i == 11) begin
`ifdef FETCH_STATS_EN
            chk("stats.fetch_count", fetch_count, 32'd7);
            chk("stats.flush_count", flush_count, 32'd2);
`else
            chk("stats.fetch_count", fetch_count, 32'd0);
            chk("stats.flush_count", flush_count, 32'd0);
`endif
         end
      end

      // Run to the end of memory
      pulse_reset();
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step(1, 0, 0);
         if (if_valid && if_pc == 32'h004003FC) found = 1'b1;
      end
      chk("end.reached", 32'(found), 32'd1);
      chk("end.last_instr", if_instr, 32'h000000FF);
      chk("end.last_req", 32'(imem_req), 32'd0);
      step(1, 0, 0);
      chk("end.fault", 32'(fetch_fault), 32'd1);
      chk("end.fault_pc", fault_pc, 32'h00400400);
      chk("end.req", 32'(imem_req), 32'd0);
      chk("end.drained", 32'(if_valid), 32'd0);
      step(1, 1, 32'h00400000);
      chk("recover.req_during_redirect", 32'(imem_req), 32'd0);
      step(1, 0, 0);
      chk("recover.fault", 32'(fetch_fault), 32'd0);
      chk("recover.fault_pc", fault_pc, 32'h0);
      chk("recover.req", 32'(imem_req), 32'd1);
      step(1, 0, 0);
      chk("recover.if_pc", if_pc, 32'h00400000);

      // Misaligned redirect
      step(1, 1, 32'h00400102);
      step(1, 0, 0);
      chk("misalign.fault", 32'(fetch_fault), 32'd1);
      chk("misalign.fault_pc", fault_pc, 32'h00400102);
      chk("misalign.valid", 32'(if_valid), 32'd0);
      chk("misalign.req", 32'(imem_req), 32'd0);
      step(1, 0, 0);
      chk("misalign.req_hold", 32'(imem_req), 32'd0);

      // Asynchronous reset with one entry queued
      step(0, 1, 32'h00400000);
      step(0, 0, 0);
      chk("midrst.pre_req", 32'(imem_req), 32'd1);
      step(0, 0, 0);
      chk("midrst.pre_valid", 32'(if_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst.valid", 32'(if_valid), 32'd0);
      chk("midrst.if_pc", if_pc, 32'h0);
      chk("midrst.if_instr", if_instr, 32'h0);
      chk("midrst.addr", imem_addr, 32'h00400000);
      chk("midrst.fault", 32'(fetch_fault), 32'd0);
      chk("midrst.fetch_count", fetch_count, 32'h0);
      chk("midrst.flush_count", flush_count, 32'h0);
      if_ready = 1'b1;
      reset = 1'b0;
      #1;
      chk("midrst.first_req", 32'(imem_req), 32'd1);
      step(1, 0, 0);
      chk("midrst.first_pc", if_pc, 32'h00400000);
      chk("midrst.first_valid", 32'(if_valid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
